seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial sequence detector: the successor to the fixed-pattern Mealy 1101 detector. Pattern length and reset pattern are parameters, and the pattern can be reloaded at run time. Overlapping or non-overlapping detection is selectable. The block provides both a Mealy output and a registered Moore-style output, plus a saturating match counter. It sits on a one-bit serial input stream, with the testbench or upstream logic driving `x` between clock edges.

## Interface
- `N`, default 4: pattern length in bits; legal range N ≥ 2.
- `PATTERN`, default 4'b1101: pattern loaded at reset. The first-received bit is the MSB.
- `CNT_W`, default 8: width of the match counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `x` input 1: serial data bit.
- `en` input 1: `x` is consumed on a rising edge only when `en` = 1.
- `overlap` input 1: 1 selects overlapping detection, 0 selects non-overlapping.
- `load` input 1: on a rising edge, loads `pat_in` into the pattern register.
- `pat_in` input N: new pattern, with the first-received bit as MSB.
- `mealy_y` output 1: combinational match flag for the current `x`.
- `moore_y` output 1: registered match flag, one cycle after `mealy_y`.
- `match_count` output CNT_W: number of matches, saturating.

## Operation
- **State registers:**
  - `pat` (N bits)
  - `hist` (N-1 bits): last accepted bits, newest in the LSB
  - `fill` (clog2(N) bits): accepted bits since the last clear, saturating at N-1
  - `moore_y`
  - `match_count`
- **Reset values** (asynchronous, while `reset` = 1):
  - `pat` = PATTERN; `hist` = 0; `fill` = 0
  - `moore_y` = 0; `match_count` = 0
  - `mealy_y` = 0, forced combinationally during reset
- **Match condition:** `mealy_y` = !reset & en & !load & (fill == N-1) & ({hist, x} == pat).
- **Rising edge, priority order:**
  1. `load` = 1:
     - `pat` ← `pat_in`; `hist` ← 0; `fill` ← 0; `match_count` ← 0; `moore_y` ← 0.
     - `x` is ignored, and `en` is irrelevant.
  2. `en` = 0: `hist`, `fill` and `match_count` hold. `moore_y` ← 0.
  3. `en` = 1 with no match:
     - `hist` ← {hist[N-3:0], x}; for N = 2, `hist` ← x.
     - `fill` ← min(fill+1, N-1).
     - `moore_y` ← 0.
  4. `en` = 1 with a match:
     - `moore_y` ← 1.
     - `match_count` ← match_count+1, unless it is all-ones, in which case it holds.
     - If `overlap` = 1: shift `hist` and saturate `fill` as in step 3. The matched bits stay available as a prefix for the next match.
     - If `overlap` = 0: `hist` ← 0 and `fill` ← 0, so the next match needs N fresh bits.
- **Overlap switching:** `overlap` may change on any cycle. It takes effect at the edge on which it is sampled.
- **Pattern reload:** a reload mid-stream discards all history. No partial-match carry-over is permitted across a reload.

## Timing
- `mealy_y` is valid combinationally in the same cycle that the final pattern bit is presented on `x` with `en` = 1. Latency is 0 cycles to the flag.
- `moore_y` rises at the edge that accepts the final bit, and stays high for exactly one cycle per match. Back-to-back overlapping matches give consecutive high cycles.
- `match_count` updates at the same edge as `moore_y`.
- **Reset asserted mid-operation:**
  - All registered outputs clear immediately, with no clock needed.
  - `mealy_y` is 0 throughout reset.
  - The first bit accepted after `reset` deasserts counts as bit 1 of a fresh stream.
- **Simultaneous events:**
  - `load` and a would-be match in the same cycle: no match and no count; `load` wins.
  - `en` = 0 on the cycle a match would have occurred: no match.
- **Counter saturation:** at 2^CNT_W − 1 further matches still pulse `mealy_y`/`moore_y`, but the count holds.

## Test plan
All scenarios use N = 4 and PATTERN = 1101 unless stated otherwise.

1. **Reset values.** Assert `reset` for 2 cycles → `mealy_y` = `moore_y` = 0 and `match_count` = 0. Then deassert `reset` and drive `x` = 1,1,0,1 with `en` = 1 → `mealy_y` is high only during the 4th bit, and `match_count` = 1.
2. **Overlapping detection.** Set `overlap` = 1 and drive `x` = 1,1,0,1,1,0,1 → `mealy_y` is high on bits 4 and 7, `moore_y` is high one cycle after each, and `match_count` = 2.
3. **Non-overlapping detection.** Set `overlap` = 0 with the same stream → a match on bit 4 only, and `match_count` = 1. Append 1,1,0,1 → a match on bit 11, and `match_count` = 2.
4. **Enable gaps.** Drive `x` = 1,1 with `en` = 1, then `x` = 0 with `en` = 0 for 3 cycles, then `x` = 0,1 with `en` = 1 → a match on the final accepted bit. The gap cycles cause no shift and no flag.
5. **Pattern reload.**
   - After one 1101 match, pulse `load` with `pat_in` = 0101 while `x` = 1 → `match_count` = 0, and no match occurs on that cycle.
   - Then drive `x` = 0,1,0,1,0,1 with `overlap` = 1 → matches on bits 4 and 6, and `match_count` = 2.
6. **Counter saturation and mid-stream reset.**
   - With CNT_W = 2, produce 5 matches → `match_count` sticks at 3, while `moore_y` still pulses 5 times.
   - Then assert `reset` between clock edges after bits 1,1,0 → all outputs read 0 immediately.
   - After deasserting `reset`, drive `x` = 1 → no match; drive 1,1,0,1 → one match.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial detector for a reloadable N-bit pattern, with Mealy and Moore flags.
// Ports: clk, reset, x, en, overlap, load, pat_in -> mealy_y, moore_y, match_count
module seq_detector_param #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  output logic             mealy_y,
  output logic             moore_y,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(N);
  localparam logic [FW-1:0] FULL = FW'(N-1);

  logic [N-1:0]     pat, pat_n;
  logic [N-2:0]     hist, hist_n;
  logic [FW-1:0]    fill, fill_n;
  logic [CNT_W-1:0] cnt_n;
  logic             moore_n;
  logic [N-1:0]     cat;

  // candidate window: stored history plus the bit on the wire
  assign cat = {hist, x};

  always_comb begin
    mealy_y = !reset && en && !load
              && (fill == FULL) && (cat == pat);
    pat_n   = pat;
    hist_n  = hist;
    fill_n  = fill;
    cnt_n   = match_count;
    moore_n = 1'b0;
    if (load) begin
      pat_n  = pat_in;
      hist_n = '0;
      fill_n = '0;
      cnt_n  = '0;
    end else if (en) begin
      if (mealy_y) begin
        moore_n = 1'b1;
        if (!(&match_count))
          cnt_n = match_count + 1'b1;
      end
      // without overlap a match consumes its bits
      if (mealy_y && !overlap) begin
        hist_n = '0;
        fill_n = '0;
      end else begin
        hist_n = cat[N-2:0];
        if (fill != FULL)
          fill_n = fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat         <= PATTERN;
      hist        <= '0;
      fill        <= '0;
      moore_y     <= 1'b0;
      match_count <= '0;
    end else begin
      pat         <= pat_n;
      hist        <= hist_n;
      fill        <= fill_n;
      moore_y     <= moore_n;
      match_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios then random traffic,
// checked against a bit-queue reference model.
module tb_seq_detector_param;

  localparam int N = 4;
  localparam logic [N-1:0] PAT0 = 4'b1101;

  logic clk = 1'b0;
  logic reset, x, en, overlap, load;
  logic [N-1:0] pat_in;
  logic mealy_y, moore_y, mealy2, moore2;
  logic [7:0] match_count;
  logic [1:0] mc2;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  bit q[$];
  logic [N-1:0] pat_m;
  int m_total;
  bit moore_m;

  always #5 clk = ~clk;

  seq_detector_param #(.N(N), .PATTERN(PAT0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .x(x), .en(en),
    .overlap(overlap), .load(load), .pat_in(pat_in),
    .mealy_y(mealy_y), .moore_y(moore_y),
    .match_count(match_count)
  );

  seq_detector_param #(.N(N), .PATTERN(PAT0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .en(en),
    .overlap(overlap), .load(load), .pat_in(pat_in),
    .mealy_y(mealy2), .moore_y(moore2),
    .match_count(mc2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pattern seen iff the last N-1 accepted bits then x spell it out
  function automatic bit ref_hit(input bit xi);
    int v;
    v = 0;
    if (q.size() != N-1) return 1'b0;
    foreach (q[i]) v = v * 2 + int'(q[i]);
    v = v * 2 + int'(xi);
    return v == int'(pat_m);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step(input bit xi, input bit ei, input bit oi,
                      input bit li, input logic [N-1:0] pi);
    bit hit;
    x = xi; en = ei; overlap = oi; load = li; pat_in = pi;
    #1;
    hit = ei && !li && ref_hit(xi);
    chk("mealy", 32'(mealy_y), 32'(hit));
    chk("mealy_c2", 32'(mealy2), 32'(hit));
    @(posedge clk);
    #1;
    if (li) begin
      pat_m = pi;
      q.delete();
      m_total = 0;
      moore_m = 1'b0;
    end else if (!ei) begin
      moore_m = 1'b0;
    end else begin
      moore_m = hit;
      if (hit) m_total++;
      if (hit && !oi) q.delete();
      else begin
        q.push_back(xi);
        if (q.size() > N-1) q.delete(0);
      end
    end
    if (moore2) pulses++;
    chk("moore", 32'(moore_y), 32'(moore_m));
    chk("moore_c2", 32'(moore2), 32'(moore_m));
    chk("count", 32'(match_count), 32'(sat(m_total, 255)));
    chk("count_c2", 32'(mc2), 32'(sat(m_total, 3)));
  endtask

  task automatic run(input logic [15:0] bits, input int n, input bit oi);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) step(b[i], 1'b1, oi, 1'b0, '0);
  endtask

  task automatic do_reset(input int cyc);
    x = 1'b1; en = 1'b1; load = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mealy", 32'(mealy_y), 0);
    chk("rst_mealy_c2", 32'(mealy2), 0);
    chk("rst_moore", 32'(moore_y), 0);
    chk("rst_moore_c2", 32'(moore2), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_count_c2", 32'(mc2), 0);
    q.delete();
    pat_m = PAT0;
    m_total = 0;
    moore_m = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
    chk("rst_hold_mealy", 32'(mealy_y), 0);
    chk("rst_hold_count", 32'(match_count), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; en = 1'b0;
    overlap = 1'b1; load = 1'b0; pat_in = '0;

    do_reset(2);
    run(16'b1101, 4, 1'b1);
    chk("t1_count", 32'(match_count), 1);

    step(1'b0, 1'b1, 1'b1, 1'b1, PAT0);
    run(16'b1101101, 7, 1'b1);
    chk("t2_count", 32'(match_count), 2);

    step(1'b0, 1'b1, 1'b0, 1'b1, PAT0);
    run(16'b1101101, 7, 1'b0);
    chk("t3_count_a", 32'(match_count), 1);
    run(16'b1101, 4, 1'b0);
    chk("t3_count_b", 32'(match_count), 2);

    step(1'b0, 1'b1, 1'b1, 1'b1, PAT0);
    run(16'b11, 2, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    run(16'b01, 2, 1'b1);
    chk("t4_count", 32'(match_count), 1);

    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101);
    chk("t5_reload_count", 32'(match_count), 0);
    run(16'b010101, 6, 1'b1);
    chk("t5_count", 32'(match_count), 2);

    step(1'b0, 1'b1, 1'b1, 1'b1, PAT0);
    pulses = 0;
    run(16'b1101101101101101, 16, 1'b1);
    chk("t6_count8", 32'(match_count), 5);
    chk("t6_count2", 32'(mc2), 3);
    chk("t6_pulses", 32'(pulses), 5);
    run(16'b110, 3, 1'b1);
    do_reset(1);
    run(16'b1, 1, 1'b1);
    chk("t6_nomatch", 32'(match_count), 0);
    run(16'b1101, 4, 1'b1);
    chk("t6_after_rst", 32'(match_count), 1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(79) == 0) begin
        do_reset(1);
      end else begin
        step(1'($urandom_range(1)),
             $urandom_range(3) != 0,
             1'($urandom_range(1)),
             $urandom_range(29) == 0,
             4'($urandom_range(15)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
